// File: rtl/debouncer_pkg.sv
// Shared IO constants and counter-width helper for the debouncer and its sample timer.
package debouncer_pkg;

    localparam int DEBOUNCE_SAMPLE_CNT_MAX = 62500;
    localparam int DEBOUNCE_PULSE_CNT_MAX  = 200;

    // Bits needed to hold values 0..max_val-1; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/debounce_sample_timer.sv
// Free-running sample timer: one-cycle sample_tick every SAMPLE_CNT_MAX clocks.
module debounce_sample_timer
    import debouncer_pkg::*;
#(
    parameter int SAMPLE_CNT_MAX = DEBOUNCE_SAMPLE_CNT_MAX
) (
    input  logic clk,
    input  logic rst_n,
    output logic sample_tick
);

    localparam int              CW   = cnt_width(SAMPLE_CNT_MAX);
    localparam logic [CW-1:0]   LAST = CW'(SAMPLE_CNT_MAX - 1);

    logic [CW-1:0] sample_cnt_q;
    logic [CW-1:0] sample_cnt_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        sample_tick  = (sample_cnt_q == LAST);
        sample_cnt_d = sample_cnt_q + CW'(1);
        if (sample_tick) begin
            sample_cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

endmodule

// File: rtl/debouncer.sv
// Per-bit debouncer: a bit goes high after PULSE_CNT_MAX consecutive high sample ticks.
// Optional DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer per bit ahead of the counters.
module debouncer
    import debouncer_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = DEBOUNCE_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = DEBOUNCE_PULSE_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal
);

    localparam int            PW   = cnt_width(PULSE_CNT_MAX + 1);
    localparam logic [PW-1:0] PMAX = PW'(PULSE_CNT_MAX);

    logic             sample_tick;
    logic [WIDTH-1:0] level;

    debounce_sample_timer #(
        .SAMPLE_CNT_MAX(SAMPLE_CNT_MAX)
    ) u_sample_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_tick(sample_tick)
    );

`ifdef DEBOUNCE_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= glitchy_signal;
            sync2_q <= sync1_q;
        end
    end

    assign level = sync2_q;
`else
    assign level = glitchy_signal;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [PW-1:0] pc_q;
        logic [PW-1:0] pc_d;

        // A low level clears the count on any cycle; the count saturates at PMAX.
        always_comb begin
            pc_d = pc_q;
            if (!level[i]) begin
                pc_d = '0;
            end else if (sample_tick && (pc_q < PMAX)) begin
                pc_d = pc_q + PW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pc_q <= '0;
            end else begin
                pc_q <= pc_d;
            end
        end

        assign debounced_signal[i] = (pc_q == PMAX);
    end

endmodule
